// File: rtl/enc16x4_seq.sv
// Sequential 16-to-4 encoder: captures a request mask and emits each set index as a code with valid/ready handshake.
// Define ENC_MSB_FIRST_EN to emit the highest index first; default order is ascending.
module enc16x4_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] d,
  input  logic        ld,
  input  logic        rdy_in,
  output logic [3:0]  code,
  output logic        valid,
  output logic        busy,
  output logic        done,
  output logic        multi,
  output logic [4:0]  cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [15:0] r_mask;
  logic [3:0]  r_code;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;
  logic        r_multi;
  logic [4:0]  r_cnt;

  logic [15:0] w_mask_left;
  logic [3:0]  w_d_code;
  logic [3:0]  w_left_code;
  logic        w_xfer;

  // Selects the index to present next from a mask; returns 0 for an empty mask.
  function automatic logic [3:0] pick(input logic [15:0] m);
    logic [3:0] idx;
    idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < 16; i++)
      if (m[i]) idx = 4'(i);
`else
    for (int i = 15; i >= 0; i--)
      if (m[i]) idx = 4'(i);
`endif
    return idx;
  endfunction

  assign w_xfer      = r_valid & rdy_in;
  assign w_mask_left = r_mask & ~(16'd1 << r_code);
  assign w_d_code    = pick(d);
  assign w_left_code = pick(w_mask_left);

  // NOTE: every register here, including the pending mask, is a flop and is cleared by reset;
  // all state updates use non-blocking assignments so each edge sees the previous values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_multi <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ld) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (d != 16'd0) begin
              r_mask  <= d;
              r_multi <= (d & (d - 16'd1)) != 16'd0;
              r_code  <= w_d_code;
              r_valid <= 1'b1;
              r_state <= S_EMIT;
            end else begin
              r_multi <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_EMIT: begin
          if (w_xfer) begin
            r_mask <= w_mask_left;
            r_cnt  <= r_cnt + 5'd1;
            // Last transfer drops valid on the same edge; otherwise the next code follows with no bubble.
            if (w_mask_left == 16'd0) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_code <= w_left_code;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign code  = r_code;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;
  assign multi = r_multi;
  assign cnt   = r_cnt;

endmodule

// File: tb/tb_enc16x4_seq.sv
// Self-checking bench for enc16x4_seq: directed batches plus randomized requests and ready patterns against a queue model.
module tb_enc16x4_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] d = '0;
  logic        ld = 1'b0;
  logic        rdy_in = 1'b0;
  logic [3:0]  code;
  logic        valid;
  logic        busy;
  logic        done;
  logic        multi;
  logic [4:0]  cnt;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  logic [3:0] last_code = '0;

  enc16x4_seq dut (
    .clk(clk), .rst_n(rst_n), .d(d), .ld(ld), .rdy_in(rdy_in),
    .code(code), .valid(valid), .busy(busy), .done(done), .multi(multi), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected emission order: the set bit positions of the request, sorted in emit direction.
  task automatic load_model(input logic [15:0] dv);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (dv[i]) begin
`ifdef ENC_MSB_FIRST_EN
        exp_q.push_front(i);
`else
        exp_q.push_back(i);
`endif
      end
    end
  endtask

  // policy: 0 = always ready, 1 = random ready, 2 = ready held low for the first 3 cycles
  task automatic run_batch(input logic [15:0] dv, input int policy, input string name);
    int   n_acc;
    int   cyc;
    bit   r;
    logic exp_multi;
    n_acc = 0;
    cyc = 0;
    load_model(dv);
    exp_multi = ($countones(dv) > 1);
    d = dv;
    ld = 1'b1;
    rdy_in = 1'b0;
    tick;
    ld = 1'b0;
    while (exp_q.size() > 0 && cyc < 300) begin
      checks++;
      if (valid !== 1'b1 || code !== 4'(exp_q[0]) || cnt !== 5'(n_acc) || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL %s_emit cyc=%0d: valid=%b code=%0d cnt=%0d busy=%b done=%b, expected 1 %0d %0d 1 0",
                 name, cyc, valid, code, cnt, busy, done, exp_q[0], n_acc);
      end
      if (policy == 0) r = 1'b1;
      else if (policy == 2) r = (cyc >= 3);
      else r = 1'($urandom_range(0, 1));
      rdy_in = r;
      ld = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      tick;
      cyc++;
      if (r) begin
        last_code = 4'(exp_q.pop_front());
        n_acc++;
      end
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: %0d codes still pending, expected 0", name, exp_q.size());
    end
    checks++;
    if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || cnt !== 5'(n_acc) || multi !== exp_multi) begin
      failures++;
      $display("FAIL %s_done: valid=%b done=%b busy=%b cnt=%0d multi=%b, expected 0 1 1 %0d %b",
               name, valid, done, busy, cnt, multi, n_acc, exp_multi);
    end
    // ld with a fresh request in the DONE cycle must be ignored.
    ld = 1'b1;
    d = 16'($urandom) | 16'd1;
    rdy_in = 1'($urandom_range(0, 1));
    tick;
    ld = 1'b0;
    rdy_in = 1'b0;
    checks++;
    if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || code !== last_code || cnt !== 5'(n_acc) || multi !== exp_multi) begin
      failures++;
      $display("FAIL %s_idle: valid=%b done=%b busy=%b code=%0d cnt=%0d multi=%b, expected 0 0 0 %0d %0d %b",
               name, valid, done, busy, code, cnt, multi, last_code, n_acc, exp_multi);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ld = 1'b1;
    d = 16'hFFFF;
    rdy_in = 1'b1;
    tick;
    tick;
    checks++;
    if (code !== 4'd0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || multi !== 1'b0 || cnt !== 5'd0) begin
      failures++;
      $display("FAIL reset: code=%0d valid=%b busy=%b done=%b multi=%b cnt=%0d, expected all 0",
               code, valid, busy, done, multi, cnt);
    end
    rst_n = 1'b1;
    ld = 1'b0;
    rdy_in = 1'b0;
    tick;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: valid=%b busy=%b, expected 0 0", valid, busy);
    end
    last_code = '0;
  endtask

  task automatic test_single;      run_batch(16'h0010, 0, "single");  endtask
  task automatic test_back_to_back; run_batch(16'h8421, 0, "b2b");    endtask
  task automatic test_stall;       run_batch(16'h0006, 2, "stall");   endtask
  task automatic test_full;        run_batch(16'hFFFF, 0, "full");    endtask

  task automatic test_zero;
    // Empty request: straight to DONE, code keeps whatever it last showed.
    d = 16'h0000;
    ld = 1'b1;
    rdy_in = 1'b1;
    tick;
    ld = 1'b0;
    checks++;
    if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || cnt !== 5'd0 || multi !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: valid=%b done=%b busy=%b cnt=%0d multi=%b, expected 0 1 1 0 0",
               valid, done, busy, cnt, multi);
    end
    tick;
    checks++;
    if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || code !== last_code || cnt !== 5'd0) begin
      failures++;
      $display("FAIL zero_idle: valid=%b done=%b busy=%b code=%0d cnt=%0d, expected 0 0 0 %0d 0",
               valid, done, busy, code, cnt, last_code);
    end
    rdy_in = 1'b0;
  endtask

  task automatic test_reset_mid;
    load_model(16'h1248);
    d = 16'h1248;
    ld = 1'b1;
    tick;
    ld = 1'b0;
    rdy_in = 1'b1;
    tick;
    tick;
    checks++;
    if (valid !== 1'b1 || cnt !== 5'd2 || code !== 4'(exp_q[2])) begin
      failures++;
      $display("FAIL midrst_pre: valid=%b cnt=%0d code=%0d, expected 1 2 %0d", valid, cnt, code, exp_q[2]);
    end
    rst_n = 1'b0;
    ld = 1'b1;
    tick;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || cnt !== 5'd0 || done !== 1'b0 || code !== 4'd0 || multi !== 1'b0) begin
      failures++;
      $display("FAIL midrst: valid=%b busy=%b cnt=%0d done=%b code=%0d multi=%b, expected 0 0 0 0 0 0",
               valid, busy, cnt, done, code, multi);
    end
    rst_n = 1'b1;
    ld = 1'b0;
    rdy_in = 1'b0;
    tick;
    checks++;
    if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_after: done=%b valid=%b busy=%b, expected 0 0 0", done, valid, busy);
    end
    last_code = '0;
  endtask

  task automatic test_random;
    logic [15:0] dv;
    for (int n = 0; n < 8; n++) begin
      dv = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      if (dv == 16'h0000) test_zero;
      else run_batch(dv, 1, "rand");
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_stall;
    test_full;
    test_zero;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
